// File: rtl/raxi_reader.sv
// AXI4 read master: splits a word-count command into INCR bursts that never
// cross a 4 KB boundary, and streams the returned data out through a FIFO.
module raxi_reader #(
    parameter int AddrWidth = 32,
    parameter int DataWidth = 32,
    parameter int IdWidth   = 8,
    parameter int MaxBurst  = 16,
    parameter int FifoDepth = 16
) (
    input  logic                 axi_clk_i,
    input  logic                 rstn_i,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic [AddrWidth-1:0] cmd_addr_i,
    input  logic [15:0]          cmd_len_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 error_o,
    output logic [DataWidth-1:0] data_o,
    output logic                 data_valid_o,
    input  logic                 data_ready_i,
    output logic [IdWidth-1:0]   m_axi_arid_o,
    output logic [AddrWidth-1:0] m_axi_araddr_o,
    output logic [7:0]           m_axi_arlen_o,
    output logic [2:0]           m_axi_arsize_o,
    output logic [1:0]           m_axi_arburst_o,
    output logic [1:0]           m_axi_arlock_o,
    output logic [3:0]           m_axi_arcache_o,
    output logic [2:0]           m_axi_arprot_o,
    output logic                 m_axi_arvalid_o,
    input  logic                 m_axi_arready_i,
    input  logic [IdWidth-1:0]   m_axi_rid_i,
    input  logic [DataWidth-1:0] m_axi_rdata_i,
    input  logic [1:0]           m_axi_rresp_i,
    input  logic                 m_axi_rlast_i,
    input  logic                 m_axi_rvalid_i,
    output logic                 m_axi_rready_o
);

    // state | meaning
    // IDLE  | waiting for a command, cmd_ready high
    // ADDR  | burst sized; AR issued once the FIFO has room for the whole burst
    // DATA  | accepting R beats into the FIFO until the beat counter hits blen
    typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA} state_t;

    localparam int SizeLog = $clog2(DataWidth / 8);
    localparam int PtrW    = $clog2(FifoDepth);
    localparam int CntW    = PtrW + 1;
    localparam int BlenW   = 9;
    localparam logic [AddrWidth-1:0] AlignMask = ~AddrWidth'((1 << SizeLog) - 1);

    state_t state_q, state_d;

    logic [AddrWidth-1:0] addr_q;
    logic [15:0]          rem_q;
    logic [BlenW-1:0]     blen_q;
    logic [BlenW-1:0]     beat_q;
    logic                 done_zero_q;
    logic                 error_q;

    logic [DataWidth-1:0] mem [FifoDepth];
    logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]      count_q;

    logic [12:0] bnd_bytes;
    logic [16:0] bnd_words;
    logic [16:0] blen_c;
    logic [CntW-1:0] free_c;
    logic space_ok, cmd_fire, ar_fire, beat_fire, last_beat, beat_bad, push, pop, fifo_empty;

    // Burst length: bounded by what is left, MaxBurst, and the next 4 KB page.
    always_comb begin
        bnd_bytes = 13'h1000 - {1'b0, addr_q[11:0]};
        bnd_words = 17'(bnd_bytes >> SizeLog);
        blen_c    = {1'b0, rem_q};
        if (blen_c > 17'(MaxBurst)) blen_c = 17'(MaxBurst);
        if (blen_c > bnd_words)     blen_c = bnd_words;
    end

    assign free_c     = CntW'(FifoDepth) - count_q;
    assign space_ok   = 17'(free_c) >= blen_c;
    assign cmd_fire   = (state_q == ST_IDLE) && cmd_valid_i;
    assign ar_fire    = m_axi_arvalid_o && m_axi_arready_i;
    assign beat_fire  = (state_q == ST_DATA) && m_axi_rvalid_i;
    assign last_beat  = (beat_q == blen_q - BlenW'(1));
    assign beat_bad   = (m_axi_rresp_i != 2'b00) || (m_axi_rid_i != '0) ||
                        (m_axi_rlast_i != last_beat);
    assign fifo_empty = (count_q == '0);
    assign push       = beat_fire;
    assign pop        = !fifo_empty && data_ready_i;

    always_ff @(posedge axi_clk_i or negedge rstn_i) begin
        if (!rstn_i) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (cmd_fire && (cmd_len_i != '0)) state_d = ST_ADDR;
            ST_ADDR: if (ar_fire) state_d = ST_DATA;
            ST_DATA: if (beat_fire && last_beat)
                         state_d = (rem_q == 16'(blen_q)) ? ST_IDLE : ST_ADDR;
            default: state_d = ST_IDLE;
        endcase
    end

    // arvalid is combinational: addr/rem are frozen in ADDR and free space only
    // grows there, so once raised it stays raised with stable payload.
    always_comb begin
        cmd_ready_o     = (state_q == ST_IDLE);
        busy_o          = (state_q != ST_IDLE);
        m_axi_arvalid_o = (state_q == ST_ADDR) && space_ok;
        m_axi_arlen_o   = (state_q == ST_ADDR) ? 8'(blen_c - 17'd1) : 8'd0;
        m_axi_araddr_o  = addr_q;
        m_axi_rready_o  = (state_q == ST_DATA);
        done_o          = done_zero_q ||
                          (beat_fire && last_beat && (rem_q == 16'(blen_q)));
    end

    assign error_o         = error_q;
    assign m_axi_arid_o    = '0;
    assign m_axi_arsize_o  = 3'(SizeLog);
    assign m_axi_arburst_o = 2'b01;
    assign m_axi_arlock_o  = 2'b00;
    assign m_axi_arcache_o = 4'b0011;
    assign m_axi_arprot_o  = 3'b000;

    always_ff @(posedge axi_clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            addr_q      <= '0;
            rem_q       <= '0;
            blen_q      <= '0;
            beat_q      <= '0;
            done_zero_q <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            done_zero_q <= cmd_fire && (cmd_len_i == '0);
            if (cmd_fire) begin
                addr_q  <= cmd_addr_i & AlignMask;
                rem_q   <= cmd_len_i;
                error_q <= 1'b0;
            end
            if (ar_fire) begin
                blen_q <= blen_c[BlenW-1:0];
                beat_q <= '0;
            end
            if (beat_fire) begin
                if (beat_bad) error_q <= 1'b1;
                if (last_beat) begin
                    beat_q <= '0;
                    addr_q <= addr_q + (AddrWidth'(blen_q) << SizeLog);
                    rem_q  <= rem_q - 16'(blen_q);
                end else begin
                    beat_q <= beat_q + BlenW'(1);
                end
            end
        end
    end

    always_ff @(posedge axi_clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge axi_clk_i) begin
        if (push) mem[wr_ptr_q] <= m_axi_rdata_i;
    end

    assign data_valid_o = !fifo_empty;
    assign data_o       = fifo_empty ? '0 : mem[rd_ptr_q];

endmodule

// File: tb/tb_raxi_reader.sv
// Bench for raxi_reader: randomized AXI slave + stream sink, checked against a
// burst-split / word-sequence model derived from the command alone.
module tb_raxi_reader;

    logic        clk = 1'b0;
    logic        rstn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic [15:0] cmd_len;
    logic        busy, done, error;
    logic [31:0] data;
    logic        data_valid;
    logic        data_ready;
    logic [7:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst, arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid, arready;
    logic [7:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast, rvalid, rready;

    always #5 clk = ~clk;

    raxi_reader #(.AddrWidth(32), .DataWidth(32), .IdWidth(8), .MaxBurst(16), .FifoDepth(16)) dut (
        .axi_clk_i(clk), .rstn_i(rstn),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len),
        .busy_o(busy), .done_o(done), .error_o(error),
        .data_o(data), .data_valid_o(data_valid), .data_ready_i(data_ready),
        .m_axi_arid_o(arid), .m_axi_araddr_o(araddr), .m_axi_arlen_o(arlen), .m_axi_arsize_o(arsize),
        .m_axi_arburst_o(arburst), .m_axi_arlock_o(arlock), .m_axi_arcache_o(arcache),
        .m_axi_arprot_o(arprot), .m_axi_arvalid_o(arvalid), .m_axi_arready_i(arready),
        .m_axi_rid_i(rid), .m_axi_rdata_i(rdata), .m_axi_rresp_i(rresp), .m_axi_rlast_i(rlast),
        .m_axi_rvalid_i(rvalid), .m_axi_rready_o(rready)
    );

    int checks = 0;
    int errors = 0;

    // Controls written by the test sequence, read by the slave/sink process.
    int rdy_mode = 0;          // 0 always ready, 1 random, 2 never
    int ar_mode  = 0;          // 0 random arready, 1 hold arready low
    int inj_resp_beat  = -1;   // absolute beat index that returns SLVERR
    int inj_rlast_beat = -1;   // absolute beat index with flipped rlast

    // Logs written only by the slave/sink process.
    logic [31:0] ar_addr_log[$];
    int          ar_len_log[$];
    logic [2:0]  ar_size_log[$];
    logic [1:0]  ar_burst_log[$];
    logic [31:0] got[$];
    int          done_beats_log[$];
    bit          done_err_log[$];
    int          done_cnt = 0;
    int          total_beats = 0;
    int          taken = 0, popped = 0, max_occ = 0;

    // Slave and sink: drive at negedge, sample once combinational outputs settle.
    initial begin
        logic [31:0] bq_addr[$];
        int          bq_len[$];
        int          r_beat;
        bit          take_pend;
        int          occ;
        r_beat = 0; take_pend = 0;
        arready = 0; rvalid = 0; rdata = '0; rlast = 0; rresp = 2'b00; rid = '0; data_ready = 1;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                bq_addr.delete(); bq_len.delete();
                r_beat = 0; take_pend = 0; popped = taken;
                arready = 0; rvalid = 0; rlast = 0; rresp = 2'b00; rdata = '0;
                continue;
            end
            if (take_pend) begin
                r_beat++; total_beats++; taken++;
                if (r_beat == bq_len[0]) begin
                    void'(bq_addr.pop_front()); void'(bq_len.pop_front()); r_beat = 0;
                end
            end
            if (bq_len.size() > 0 && $urandom_range(0, 3) != 0) begin
                rvalid = 1;
                rdata  = bq_addr[0] + 32'(4 * r_beat);
                rlast  = (r_beat == bq_len[0] - 1) ^ (total_beats == inj_rlast_beat);
                rresp  = (total_beats == inj_resp_beat) ? 2'b10 : 2'b00;
                rid    = '0;
            end else begin
                rvalid = 0; rlast = 0; rresp = 2'b00; rdata = '0;
            end
            arready = 0;
            if (arvalid && ar_mode == 0 && $urandom_range(0, 2) != 0) begin
                arready = 1;
                ar_addr_log.push_back(araddr); ar_len_log.push_back(int'(arlen));
                ar_size_log.push_back(arsize); ar_burst_log.push_back(arburst);
                bq_addr.push_back(araddr); bq_len.push_back(int'(arlen) + 1);
            end
            case (rdy_mode)
                0: data_ready = 1;
                1: data_ready = ($urandom_range(0, 1) == 1);
                default: data_ready = 0;
            endcase
            #1;
            take_pend = rvalid && rready;
            if (data_valid && data_ready) begin got.push_back(data); popped++; end
            occ = taken + (take_pend ? 1 : 0) - popped;
            if (occ > max_occ) max_occ = occ;
            if (done) begin
                done_cnt++;
                done_beats_log.push_back(total_beats + (take_pend ? 1 : 0));
                done_err_log.push_back(error);
            end
        end
    end

    task automatic tick();
        @(negedge clk); #2;
    endtask

    task automatic issue_cmd(input logic [31:0] a, input logic [15:0] l);
        int cyc = 0;
        tick();
        cmd_valid = 1; cmd_addr = a; cmd_len = l;
        while (!cmd_ready && cyc < 100) begin tick(); cyc++; end
        checks++;
        if (!cmd_ready) begin errors++; $display("FAIL cmd_accept_timeout got cmd_ready=0 want 1"); end
        tick();
        cmd_valid = 0;
    endtask

    task automatic wait_done(input string name, input int done_base);
        int cyc = 0;
        while (done_cnt == done_base && cyc < 4000) begin tick(); cyc++; end
        checks++;
        if (done_cnt == done_base) begin errors++; $display("FAIL %s done_timeout got 0 pulses want 1", name); end
    endtask

    task automatic wait_words(input string name, input int want);
        int cyc = 0;
        while (got.size() < want && cyc < 4000) begin tick(); cyc++; end
        checks++;
        if (got.size() < want) begin
            errors++; $display("FAIL %s drain_timeout got %0d words want %0d", name, got.size(), want);
        end
    endtask

    // Full command scenario: model the burst split and the word sequence, run, compare.
    task automatic test_transfer(input string name, input logic [31:0] a, input int l,
                                 input int rmode, input bit exp_err);
        logic [31:0] ea[$];
        int el[$];
        logic [31:0] aa;
        int rem, b, bnd, ar_base, got_base, done_base, beat_base;
        aa = a & ~32'h3; rem = l;
        while (rem > 0) begin
            bnd = (4096 - int'(aa[11:0])) / 4;
            b = rem; if (b > 16) b = 16; if (b > bnd) b = bnd;
            ea.push_back(aa); el.push_back(b - 1);
            aa = aa + 32'(b * 4); rem -= b;
        end
        rdy_mode  = rmode;
        ar_base   = ar_addr_log.size(); got_base = got.size();
        done_base = done_cnt;           beat_base = total_beats;
        issue_cmd(a, 16'(l));
        wait_done(name, done_base);
        wait_words(name, got_base + l);
        repeat (3) tick();
        checks++;
        if (done_cnt - done_base != 1) begin
            errors++; $display("FAIL %s done_count got %0d want 1", name, done_cnt - done_base);
        end
        checks++;
        if (done_beats_log.size() <= done_base) begin
            errors++; $display("FAIL %s done_beat got no pulse want beat %0d", name, l);
        end else if (done_beats_log[done_base] != beat_base + l) begin
            errors++; $display("FAIL %s done_beat got %0d want %0d", name, done_beats_log[done_base] - beat_base, l);
        end else if (done_err_log[done_base] !== exp_err) begin
            errors++; $display("FAIL %s error_at_done got %0b want %0b", name, done_err_log[done_base], exp_err);
        end
        checks++;
        if (ar_addr_log.size() - ar_base != ea.size()) begin
            errors++; $display("FAIL %s ar_count got %0d want %0d", name, ar_addr_log.size() - ar_base, ea.size());
        end else begin
            foreach (ea[i]) begin
                checks++;
                if (ar_addr_log[ar_base+i] !== ea[i] || ar_len_log[ar_base+i] != el[i] ||
                    ar_size_log[ar_base+i] !== 3'd2 || ar_burst_log[ar_base+i] !== 2'b01) begin
                    errors++;
                    $display("FAIL %s ar%0d got addr=%h len=%0d size=%0d burst=%0d want addr=%h len=%0d size=2 burst=1",
                             name, i, ar_addr_log[ar_base+i], ar_len_log[ar_base+i], ar_size_log[ar_base+i],
                             ar_burst_log[ar_base+i], ea[i], el[i]);
                end
            end
        end
        checks++;
        if (got.size() - got_base != l) begin
            errors++; $display("FAIL %s word_count got %0d want %0d", name, got.size() - got_base, l);
        end else begin
            for (int i = 0; i < l; i++) begin
                checks++;
                if (got[got_base+i] !== (a & ~32'h3) + 32'(4 * i)) begin
                    errors++; $display("FAIL %s word%0d got %h want %h", name, i, got[got_base+i], (a & ~32'h3) + 32'(4 * i));
                end
            end
        end
        checks++;
        if (error !== exp_err || busy !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++; $display("FAIL %s end_state got err=%b busy=%b rdy=%b want err=%b busy=0 rdy=1",
                               name, error, busy, cmd_ready, exp_err);
        end
    endtask

    task automatic test_reset();
        rstn = 0;
        #3;
        checks++;
        if (cmd_ready !== 1 || busy !== 0 || done !== 0 || error !== 0 || data_valid !== 0 || data !== 0) begin
            errors++; $display("FAIL reset_ctrl got rdy=%b busy=%b done=%b err=%b dv=%b data=%h want 1 0 0 0 0 0",
                               cmd_ready, busy, done, error, data_valid, data);
        end
        checks++;
        if (arvalid !== 0 || rready !== 0 || araddr !== 0 || arlen !== 0) begin
            errors++; $display("FAIL reset_axi got arvalid=%b rready=%b araddr=%h arlen=%h want 0 0 0 0",
                               arvalid, rready, araddr, arlen);
        end
        checks++;
        if (arid !== 0 || arsize !== 3'd2 || arburst !== 2'b01 || arlock !== 0 || arcache !== 4'b0011 || arprot !== 0) begin
            errors++; $display("FAIL reset_const got id=%h size=%0d burst=%0d lock=%0d cache=%h prot=%0d want 0 2 1 0 3 0",
                               arid, arsize, arburst, arlock, arcache, arprot);
        end
        repeat (2) tick();
        rstn = 1;
        tick();
    endtask

    task automatic test_single();
        test_transfer("single", 32'h100, 4, 0, 1'b0);
    endtask

    task automatic test_multi_burst();
        test_transfer("multi_burst", 32'h0, 40, 0, 1'b0);
    endtask

    task automatic test_4k_boundary();
        test_transfer("boundary_4k", 32'hFF8, 4, 0, 1'b0);
        test_transfer("boundary_4k_long", 32'h1FC4, 30, 1, 1'b0);
    endtask

    task automatic test_zero_len();
        test_transfer("zero_len", 32'h700, 0, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        int ar_base, got_base, done_base;
        rdy_mode = 2;
        ar_base = ar_addr_log.size(); got_base = got.size(); done_base = done_cnt;
        issue_cmd(32'h2000, 16'd32);
        repeat (200) tick();
        checks++;
        if (ar_addr_log.size() - ar_base != 1) begin
            errors++; $display("FAIL bp_withheld got %0d ARs want 1", ar_addr_log.size() - ar_base);
        end
        checks++;
        if (taken - popped != 16 || got.size() != got_base) begin
            errors++; $display("FAIL bp_full got occupancy=%0d popped=%0d want 16 0", taken - popped, got.size() - got_base);
        end
        rdy_mode = 0;
        wait_done("backpressure", done_base);
        wait_words("backpressure", got_base + 32);
        checks++;
        if (ar_addr_log.size() - ar_base != 2) begin
            errors++; $display("FAIL bp_ar_count got %0d want 2", ar_addr_log.size() - ar_base);
        end else if (ar_addr_log[ar_base+1] !== 32'h2040 || ar_len_log[ar_base+1] != 15) begin
            errors++; $display("FAIL bp_ar2 got addr=%h len=%0d want 2040 15", ar_addr_log[ar_base+1], ar_len_log[ar_base+1]);
        end
        for (int i = 0; i < 32 && got_base + i < got.size(); i++) begin
            checks++;
            if (got[got_base+i] !== 32'h2000 + 32'(4 * i)) begin
                errors++; $display("FAIL bp_word%0d got %h want %h", i, got[got_base+i], 32'h2000 + 32'(4 * i));
            end
        end
        checks++;
        if (max_occ > 16) begin errors++; $display("FAIL fifo_overflow got %0d want <=16", max_occ); end
    endtask

    task automatic test_error_resp();
        inj_resp_beat = total_beats + 1;
        test_transfer("err_resp", 32'h300, 4, 0, 1'b1);
        inj_resp_beat = -1;
        repeat (4) tick();
        checks++;
        if (error !== 1) begin errors++; $display("FAIL err_held got %b want 1", error); end
        issue_cmd(32'h0, 16'd0);
        checks++;
        if (error !== 0) begin errors++; $display("FAIL err_clear got %b want 0", error); end
        repeat (3) tick();
    endtask

    task automatic test_early_rlast();
        inj_rlast_beat = total_beats + 1;
        test_transfer("early_rlast", 32'h404, 4, 1, 1'b1);
        inj_rlast_beat = -1;
        test_transfer("after_rlast", 32'h500, 3, 0, 1'b0);
    endtask

    task automatic test_random();
        logic [31:0] a;
        for (int n = 0; n < 8; n++) begin
            a = $urandom;
            if ($urandom_range(0, 1) == 1) a[11:0] = 12'hF00 | 12'($urandom_range(0, 255));
            test_transfer("random", a, $urandom_range(0, 60), $urandom_range(0, 1), 1'b0);
        end
    endtask

    task automatic test_reset_mid();
        int done_base, cyc;
        rdy_mode = 2;
        done_base = done_cnt;
        issue_cmd(32'h4000, 16'd4);
        wait_done("reset_mid_fill", done_base);
        repeat (4) tick();
        ar_mode = 1;
        issue_cmd(32'h5000, 16'd8);
        cyc = 0;
        while (!arvalid && cyc < 50) begin tick(); cyc++; end
        checks++;
        if (arvalid !== 1 || data_valid !== 1) begin
            errors++; $display("FAIL reset_mid_pre got arvalid=%b dv=%b want 1 1", arvalid, data_valid);
        end
        done_base = done_cnt;
        #1 rstn = 0;
        #1;
        checks++;
        if (arvalid !== 0 || busy !== 0 || data_valid !== 0 || cmd_ready !== 1 || done !== 0) begin
            errors++; $display("FAIL reset_mid_drop got arvalid=%b busy=%b dv=%b rdy=%b done=%b want 0 0 0 1 0",
                               arvalid, busy, data_valid, cmd_ready, done);
        end
        repeat (2) tick();
        rstn = 1; ar_mode = 0; rdy_mode = 0;
        repeat (5) tick();
        checks++;
        if (cmd_ready !== 1 || busy !== 0 || done_cnt != done_base) begin
            errors++; $display("FAIL reset_mid_after got rdy=%b busy=%b extra_done=%0d want 1 0 0",
                               cmd_ready, busy, done_cnt - done_base);
        end
        test_transfer("post_reset", 32'h6000, 5, 0, 1'b0);
    endtask

    initial begin
        rstn = 0; cmd_valid = 0; cmd_addr = '0; cmd_len = '0;
        test_reset();
        test_single();
        test_multi_burst();
        test_4k_boundary();
        test_zero_len();
        test_backpressure();
        test_error_resp();
        test_early_rlast();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/raxi_reader.md
Name: raxi_reader

Overview:
- Single-clock AXI4 read master that fetches a block of words from an AXI read-only slave and streams them out through an internal FIFO, e.g. the shared dual-port RAM's AXI port.
- Sits between the platform-side controller, which issues commands and consumes data, and the AXI AR/R channels.
- Splits long requests into INCR bursts, never crossing a 4 KB boundary.
- Only one burst is outstanding at a time.

Parameters:
- AddrWidth, 32: AXI address width in bits.
- DataWidth, 32: AXI/stream data width in bits (32 or 64).
- IdWidth, 8: ARID/RID width.
- MaxBurst, 16: maximum beats per burst; power of 2, 1..256.
- FifoDepth, 16: output FIFO depth in words; power of 2, at least MaxBurst.

Ports:
- axi_clk_i  in  1  clock.
- rstn_i  in  1  reset, asynchronous, active-low.
- cmd_valid_i  in  1  command request.
- cmd_ready_o  out  1  command accepted when high together with cmd_valid_i.
- cmd_addr_i  in  AddrWidth  start byte address; low log2(DataWidth/8) bits are ignored and forced to 0.
- cmd_len_i  in  16  number of words to read.
- busy_o  out  1  command in progress.
- done_o  out  1  one-cycle pulse when a command completes.
- error_o  out  1  sticky error flag.
- data_o  out  DataWidth  stream data.
- data_valid_o  out  1  stream valid.
- data_ready_i  in  1  stream ready.
- m_axi_arid_o  out  IdWidth  constant 0.
- m_axi_araddr_o  out  AddrWidth  burst start address.
- m_axi_arlen_o  out  8  beats-1.
- m_axi_arsize_o  out  3  log2(DataWidth/8).
- m_axi_arburst_o  out  2  constant 2'b01 (INCR).
- m_axi_arlock_o  out  2  constant 0.
- m_axi_arcache_o  out  4  constant 4'b0011.
- m_axi_arprot_o  out  3  constant 0.
- m_axi_arvalid_o  out  1  AR valid.
- m_axi_arready_i  in  1  AR ready.
- m_axi_rid_i  in  IdWidth  R ID.
- m_axi_rdata_i  in  DataWidth  R data.
- m_axi_rresp_i  in  2  R response.
- m_axi_rlast_i  in  1  R last.
- m_axi_rvalid_i  in  1  R valid.
- m_axi_rready_o  out  1  R ready.

Behaviour:
- Reset (asynchronous, rstn_i low): FSM goes to IDLE and the FIFO empties. Outputs then are: cmd_ready_o=1; busy_o=0; done_o=0; error_o=0; data_valid_o=0; data_o=0; m_axi_arvalid_o=0; m_axi_rready_o=0; m_axi_araddr_o=0; m_axi_arlen_o=0. Reset mid-burst abandons the transfer with no done_o pulse.
- FSM states:
  - IDLE: cmd_ready_o=1. On cmd_valid_i, latch addr/len and clear error_o. If len=0, pulse done_o on the next cycle and stay in IDLE; otherwise go to ADDR.
  - ADDR: compute blen = min(remaining, MaxBurst, words left before the next 4 KB boundary). Assert m_axi_arvalid_o only when FIFO free slots are at least blen. Once asserted, arvalid/araddr/arlen stay stable until m_axi_arready_i. On the handshake go to DATA.
  - DATA: m_axi_rready_o=1, which is safe because space was reserved. Each beat with rvalid&rready pushes rdata into the FIFO and increments the beat counter.
    - The beat counter alone defines the end of the burst; the burst ends when it reaches blen.
    - On end of burst: address += blen*(DataWidth/8), remaining -= blen.
    - If remaining=0: pulse done_o in the same cycle as the last beat and return to IDLE. Otherwise return to ADDR.
- cmd_ready_o=1 only in IDLE; busy_o = (state != IDLE).
- error_o is set and held until the next command is accepted when any of these occurs on an accepted beat:
  - rresp != 2'b00;
  - rid != 0;
  - rlast mismatches the counter (rlast=1 before the final beat, or rlast=0 on the final beat).
- Errored data is still pushed into the FIFO and the transfer continues.
- FIFO: show-ahead; data_valid_o = !empty; data_o is the head word.
  - Pop on data_valid_o & data_ready_i.
  - Simultaneous push and pop keeps the count unchanged, including when the FIFO is full (the free-slot reservation already covered the push).
  - The FIFO drains independently of the FSM; a new command may be accepted while it still holds data.
- Pointer and counter widths: log2(FifoDepth)+1 bits for the count. remaining is 16 bits. Address arithmetic wraps modulo 2^AddrWidth.
- Latency: first araddr is presented 1 cycle after command acceptance, provided free space is available. First data_valid_o is 1 cycle after the first R beat.

Test Plan:
- addr=0x100, len=4, slave with zero wait states, data_ready_i=1 -> one AR (araddr=0x100, arlen=3, arsize=2, arburst=1); words 0x100..0x10C in order; a single done_o pulse; error_o=0.
- addr=0x0, len=40, MaxBurst=16 -> three ARs with arlen 15,15,7 at 0x0, 0x40, 0x80; 40 words out; done_o after the 40th beat.
- addr=0xFF8, len=4 -> two ARs: 0xFF8 with arlen=1, then 0x1000 with arlen=1; 4KB boundary never crossed.
- data_ready_i=0, len=32, FifoDepth=16 -> second AR withheld until the FIFO pops, no R beat is lost, and the FIFO count never exceeds 16.
- rresp=2'b10 on beat 2 of len=4, plus an early rlast in a separate run -> error_o=1 held through done_o and cleared on the next command accept; all 4 words still delivered.
- rstn_i low while arvalid=1 mid-command -> arvalid/busy/data_valid drop immediately, no done_o, cmd_ready_o=1 after release.
